// File: rtl/mem_req_queue.sv
// In-order line request FIFO feeding a single-outstanding backing-memory
// sequencer; reads return through a held response/ack handshake.
module mem_req_queue #(
  parameter int PA_WIDTH   = 32,
  parameter int LINE_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_enable,
  input  logic [PA_WIDTH-1:0]   i_req_addr,
  input  logic [LINE_WIDTH-1:0] i_req_data,
  input  logic                  i_req_type,
  output logic [ID_WIDTH-1:0]   o_req_id,
  output logic                  o_req_full,
  output logic                  o_resp_enable,
  output logic [LINE_WIDTH-1:0] o_resp_data,
  output logic [ID_WIDTH-1:0]   o_resp_id,
  input  logic                  i_resp_ack,
  output logic                  o_bk_enable,
  output logic                  o_bk_we,
  output logic [PA_WIDTH-1:0]   o_bk_addr,
  output logic [LINE_WIDTH-1:0] o_bk_wdata,
  input  logic                  i_bk_ready,
  input  logic                  i_bk_valid,
  input  logic [LINE_WIDTH-1:0] i_bk_rdata,
  output logic                  o_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  typedef struct packed {
    logic [PA_WIDTH-1:0]   addr;
    logic [LINE_WIDTH-1:0] data;
    logic                  we;
    logic [ID_WIDTH-1:0]   id;
  } req_t;

  req_t fifo_mem [DEPTH];
  req_t head, new_req;

  logic [1:0]            state_q, state_d;
  logic [PW:0]           count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ID_WIDTH-1:0]   req_id_q, req_id_d, resp_id_q, resp_id_d;
  logic                  overflow_q, overflow_d;
  logic                  resp_en_q, resp_en_d;
  logic                  bk_en_q, bk_en_d, bk_we_q, bk_we_d;
  logic [PA_WIDTH-1:0]   bk_addr_q, bk_addr_d;
  logic [LINE_WIDTH-1:0] bk_wdata_q, bk_wdata_d, resp_data_q, resp_data_d;
  logic                  full, push, pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count_q == FULL_CNT);
  assign push    = i_req_enable && !full;
  assign head    = fifo_mem[rd_ptr_q];
  assign new_req = '{addr: i_req_addr, data: i_req_data, we: i_req_type, id: req_id_q};

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    bk_en_d     = bk_en_q;
    bk_we_d     = bk_we_q;
    bk_addr_d   = bk_addr_q;
    bk_wdata_d  = bk_wdata_q;
    resp_en_d   = resp_en_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        bk_en_d    = 1'b1;
        bk_we_d    = head.we;
        bk_addr_d  = head.addr;
        bk_wdata_d = head.data;
        state_d    = S_ISSUE;
      end
      S_ISSUE: if (i_bk_ready) begin
        bk_en_d = 1'b0;
        // Writes retire on command accept; reads keep the head until data returns.
        if (bk_we_q) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: if (i_bk_valid) begin
        resp_data_d = i_bk_rdata;
        resp_id_d   = head.id;
        resp_en_d   = 1'b1;
        pop         = 1'b1;
        state_d     = S_RESPOND;
      end
      default: if (i_resp_ack) begin
        resp_en_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
    count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    req_id_d   = req_id_q + ID_WIDTH'(push);
    overflow_d = overflow_q | (i_req_enable & full);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= new_req;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_id_q    <= '0;
      overflow_q  <= 1'b0;
      resp_en_q   <= 1'b0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      bk_en_q     <= 1'b0;
      bk_we_q     <= 1'b0;
      bk_addr_q   <= '0;
      bk_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_id_q    <= req_id_d;
      overflow_q  <= overflow_d;
      resp_en_q   <= resp_en_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      bk_en_q     <= bk_en_d;
      bk_we_q     <= bk_we_d;
      bk_addr_q   <= bk_addr_d;
      bk_wdata_q  <= bk_wdata_d;
    end
  end

  assign o_req_id      = req_id_q;
  assign o_req_full    = full;
  assign o_overflow    = overflow_q;
  assign o_resp_enable = resp_en_q;
  assign o_resp_id     = resp_id_q;
  assign o_resp_data   = resp_data_q;
  assign o_bk_enable   = bk_en_q;
  assign o_bk_we       = bk_we_q;
  assign o_bk_addr     = bk_addr_q;
  assign o_bk_wdata    = bk_wdata_q;
endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: a read scoreboard filled on accept and
// drained on response handshake, plus a log of backing-memory commands.
module tb_mem_req_queue;
  localparam int PA = 32;
  localparam int LW = 128;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_enable;
  logic [PA-1:0] i_req_addr;
  logic [LW-1:0] i_req_data;
  logic          i_req_type;
  logic [IW-1:0] o_req_id;
  logic          o_req_full;
  logic          o_resp_enable;
  logic [LW-1:0] o_resp_data;
  logic [IW-1:0] o_resp_id;
  logic          i_resp_ack;
  logic          o_bk_enable;
  logic          o_bk_we;
  logic [PA-1:0] o_bk_addr;
  logic [LW-1:0] o_bk_wdata;
  logic          i_bk_ready;
  logic          i_bk_valid;
  logic [LW-1:0] i_bk_rdata;
  logic          o_overflow;

  mem_req_queue #(.PA_WIDTH(PA), .LINE_WIDTH(LW), .ID_WIDTH(IW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_enable(i_req_enable), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_req_type(i_req_type), .o_req_id(o_req_id), .o_req_full(o_req_full),
    .o_resp_enable(o_resp_enable), .o_resp_data(o_resp_data), .o_resp_id(o_resp_id),
    .i_resp_ack(i_resp_ack), .o_bk_enable(o_bk_enable), .o_bk_we(o_bk_we),
    .o_bk_addr(o_bk_addr), .o_bk_wdata(o_bk_wdata), .i_bk_ready(i_bk_ready),
    .i_bk_valid(i_bk_valid), .i_bk_rdata(i_bk_rdata), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [IW-1:0] id; logic [LW-1:0] data; } exp_t;
  typedef struct packed { logic we; logic [PA-1:0] addr; logic [LW-1:0] wdata; } cmd_t;

  exp_t          sb[$];
  cmd_t          bk_log[$];
  int            n_cmp = 0, n_bad = 0;
  int            resp_count = 0, resp_hi = 0, n_acc = 0, hi0 = 0;
  logic [IW-1:0] exp_id = '0;
  logic [IW-1:0] last_resp_id = '0;
  logic [LW-1:0] rdata_pat = '0;
  logic          mem_auto = 1'b1, force_valid = 1'b0, auto_ack = 1'b0;

  assign i_bk_rdata = rdata_pat;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++; $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++; $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++; $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe the handshakes that the coming edge completes, then
  // let the memory model and ack model react just after the edge.
  task automatic tick();
    exp_t e;
    logic fire_rd;
    fire_rd = o_bk_enable && i_bk_ready && !o_bk_we;
    if (!rst) begin
      sb.delete();
      exp_id = '0;
    end else begin
      if (i_req_enable && !o_req_full) begin
        if (!i_req_type) sb.push_back('{id: exp_id, data: rdata_pat});
        exp_id++;
        n_acc++;
      end
      if (o_bk_enable && i_bk_ready) bk_log.push_back('{we: o_bk_we, addr: o_bk_addr, wdata: o_bk_wdata});
      if (o_resp_enable && i_resp_ack) begin
        resp_count++;
        last_resp_id = o_resp_id;
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_bad++; $error("FAIL resp_expected: got response id %0d expected none", o_resp_id);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk_i("resp_id", int'(o_resp_id), int'(e.id));
          chk_w("resp_data", o_resp_data, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
    i_bk_valid = (mem_auto && fire_rd) || force_valid;
    if (auto_ack) i_resp_ack = o_resp_enable;
    if (o_resp_enable) resp_hi++;
  endtask

  task automatic send(input logic we, input logic [PA-1:0] a, input logic [LW-1:0] d);
    i_req_enable = 1'b1; i_req_type = we; i_req_addr = a; i_req_data = d;
    tick();
    i_req_enable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; i_req_enable = 1'b0; i_req_addr = '0; i_req_data = '0; i_req_type = 1'b0;
    i_resp_ack = 1'b0; i_bk_ready = 1'b0; i_bk_valid = 1'b0;
    repeat (3) tick();
    chk_i("rst_req_id", int'(o_req_id), 0);
    chk_b("rst_full", o_req_full, 1'b0);
    chk_b("rst_resp_en", o_resp_enable, 1'b0);
    chk_b("rst_bk_en", o_bk_enable, 1'b0);
    chk_b("rst_bk_we", o_bk_we, 1'b0);
    chk_b("rst_overflow", o_overflow, 1'b0);

    // Single read with minimum latency, response held until ack.
    rst = 1'b1;
    i_bk_ready = 1'b1;
    rdata_pat = {16{8'hAA}};
    send(1'b0, 32'h100, '0);
    chk_i("t1_next_id", int'(o_req_id), 1);
    chk_b("t1_bk_en_n1", o_bk_enable, 1'b0);
    tick();
    chk_b("t1_bk_en_n2", o_bk_enable, 1'b1);
    chk_i("t1_bk_addr", int'(o_bk_addr), 32'h100);
    chk_b("t1_bk_we", o_bk_we, 1'b0);
    tick();
    chk_b("t1_bk_en_off", o_bk_enable, 1'b0);
    chk_b("t1_resp_early", o_resp_enable, 1'b0);
    tick();
    chk_b("t1_resp_n4", o_resp_enable, 1'b1);
    chk_i("t1_resp_id", int'(o_resp_id), 0);
    chk_w("t1_resp_data", o_resp_data, {16{8'hAA}});
    repeat (2) tick();
    chk_b("t1_resp_hold", o_resp_enable, 1'b1);
    chk_w("t1_resp_data_hold", o_resp_data, {16{8'hAA}});
    i_resp_ack = 1'b1;
    tick();
    i_resp_ack = 1'b0;
    chk_b("t1_resp_clear", o_resp_enable, 1'b0);
    chk_i("t1_sb_empty", sb.size(), 0);

    // Write then read to one address: write command reaches memory first.
    do_reset();
    auto_ack = 1'b1;
    bk_log.delete();
    resp_count = 0;
    rdata_pat = {4{32'h1234_5678}};
    send(1'b1, 32'h200, {4{32'hDEAD_BEEF}});
    send(1'b0, 32'h200, '0);
    repeat (12) tick();
    chk_i("t2_cmds", bk_log.size(), 2);
    if (bk_log.size() == 2) begin
      chk_b("t2_first_we", bk_log[0].we, 1'b1);
      chk_i("t2_first_addr", int'(bk_log[0].addr), 32'h200);
      chk_w("t2_first_wdata", bk_log[0].wdata, {4{32'hDEAD_BEEF}});
      chk_b("t2_second_we", bk_log[1].we, 1'b0);
      chk_i("t2_second_addr", int'(bk_log[1].addr), 32'h200);
    end
    chk_i("t2_resp_count", resp_count, 1);
    chk_i("t2_resp_id", int'(last_resp_id), 1);

    // Fill with memory stalled: fifth request dropped and flagged.
    do_reset();
    i_bk_ready = 1'b0;
    rdata_pat = {16{8'h55}};
    resp_count = 0;
    i_req_enable = 1'b1; i_req_type = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_req_addr = 32'h300 + 32'(i * 16);
      tick();
    end
    chk_b("t3_full_4", o_req_full, 1'b1);
    chk_b("t3_ovf_4", o_overflow, 1'b0);
    i_req_addr = 32'h340;
    tick();
    i_req_enable = 1'b0;
    chk_b("t3_ovf_5", o_overflow, 1'b1);
    chk_i("t3_req_id", int'(o_req_id), 4);
    chk_i("t3_sb_depth", sb.size(), 4);
    i_bk_ready = 1'b1;
    repeat (30) tick();
    chk_i("t3_resp_count", resp_count, 4);
    chk_b("t3_full_drain", o_req_full, 1'b0);
    chk_b("t3_ovf_sticky", o_overflow, 1'b1);

    // ID wrap: sixteen writes, then the seventeenth request reuses id 0.
    do_reset();
    n_acc = 0;
    i_req_enable = 1'b1; i_req_type = 1'b1; i_req_addr = 32'h600;
    for (int i = 0; i < 200 && n_acc < 16; i++) tick();
    i_req_enable = 1'b0;
    chk_i("t4_accepted", n_acc, 16);
    chk_i("t4_id_wrapped", int'(o_req_id), 0);
    repeat (12) tick();
    resp_count = 0;
    rdata_pat = {2{64'h0F0F_0F0F_A5A5_A5A5}};
    send(1'b0, 32'h400, '0);
    repeat (8) tick();
    chk_i("t4_resp_count", resp_count, 1);
    chk_i("t4_resp_id", int'(last_resp_id), 0);

    // Spurious ack and read-valid while idle.
    auto_ack = 1'b0;
    hi0 = resp_hi;
    force_valid = 1'b1; i_resp_ack = 1'b1;
    repeat (3) tick();
    force_valid = 1'b0; i_resp_ack = 1'b0;
    tick();
    chk_i("t5_no_resp", resp_hi, hi0);
    chk_b("t5_bk_idle", o_bk_enable, 1'b0);
    chk_i("t5_id_kept", int'(o_req_id), int'(exp_id));
    auto_ack = 1'b1;
    resp_count = 0;
    send(1'b0, 32'h500, '0);
    repeat (8) tick();
    chk_i("t5_resp_after", resp_count, 1);
    chk_i("t5_sb_empty", sb.size(), 0);

    // Reset while a read waits for data with two more queued.
    mem_auto = 1'b0;
    rdata_pat = {16{8'h77}};
    send(1'b0, 32'h700, '0);
    send(1'b0, 32'h710, '0);
    send(1'b0, 32'h720, '0);
    repeat (3) tick();
    chk_b("t6_waiting", o_bk_enable, 1'b0);
    hi0 = resp_hi;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    repeat (6) tick();
    chk_i("t6_no_resp", resp_hi, hi0);
    chk_b("t6_bk_idle", o_bk_enable, 1'b0);
    chk_i("t6_req_id", int'(o_req_id), 0);
    chk_b("t6_full", o_req_full, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
